// File: rtl/sb_issue_checker.sv
// -----------------------------------------------------------------------------
// sb_issue_checker
//
// Issue-side consumer of the register scoreboard. Holds one decoded
// instruction, reads the scoreboard entry of each source register through the
// single combinational read port (source A, then source B, one per cycle), and
// stalls until neither used source is pending. The hazard-free instruction is
// then offered downstream. On acceptance the destination register is marked
// pending with the stage at which its result appears.
//
// Optional feature macro: SB_FWD_EN
//   defined   : a pending source whose recorded stage is >= FWD_STAGE is taken
//               from the bypass network instead of stalling (out_fwd_x = 1).
//   undefined : every pending used source stalls; out_fwd_a/b are tied to 0.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready is high only in IDLE)
//   in_src_a/b, in_use_a/b, in_dest, in_writes, in_stage
//                         decoded instruction fields
//   flush                 synchronous abort of the held instruction
//   out_valid / out_ready downstream handshake
//   out_fwd_a/b           take source from bypass network
//   stall_count           stall rounds spent on the current instruction
//   sb_addr / sb_data     scoreboard read port (sb_data[7] = pending,
//                         sb_data[SW-1:0] = stage)
//   sb_writeaddr, sb_registerstage, sb_enablewrite
//                         scoreboard pending-set strobe
// -----------------------------------------------------------------------------
module sb_issue_checker #(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int DW        = 8,
  parameter int SW        = 2,
  parameter int FWD_STAGE = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_src_a,
  input  logic [AW-1:0] in_src_b,
  input  logic          in_use_a,
  input  logic          in_use_b,
  input  logic [AW-1:0] in_dest,
  input  logic          in_writes,
  input  logic [SW-1:0] in_stage,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_fwd_a,
  output logic          out_fwd_b,
  output logic [7:0]    stall_count,
  output logic [AW-1:0] sb_addr,
  input  logic [DW-1:0] sb_data,
  output logic [AW-1:0] sb_writeaddr,
  output logic [SW-1:0] sb_registerstage,
  output logic          sb_enablewrite
);

  localparam int PEND_BIT = 7;

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, ISSUE} state_t;

  state_t        state;
  logic [AW-1:0] src_a_q, src_b_q, dest_q;
  logic          use_a_q, use_b_q, writes_q;
  logic [SW-1:0] stage_q;
  logic          haz_a_q;
  logic [7:0]    stall_q;

  // Scoreboard entry decode for the source currently on the read port.
  logic          sb_pending;
  logic [SW-1:0] sb_stage;
  logic          cur_use;
  logic [AW-1:0] cur_src;
  logic          live;      // used, non-zero source with a pending result
  logic          fwdable;
  logic          haz_now;
  logic          fwd_now;

  assign sb_pending = sb_data[PEND_BIT];
  assign sb_stage   = sb_data[SW-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    cur_src = src_a_q;
    cur_use = use_a_q;
    if (state == RD_B) begin
      cur_src = src_b_q;
      cur_use = use_b_q;
    end
  end

  assign live = cur_use & (cur_src != '0) & sb_pending;

`ifdef SB_FWD_EN
  assign fwdable = sb_pending & (int'(sb_stage) >= FWD_STAGE);
`else
  assign fwdable = 1'b0;
`endif

  assign haz_now = live & ~fwdable;
  assign fwd_now = live &  fwdable;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dest_q   <= '0;
      use_a_q  <= 1'b0;
      use_b_q  <= 1'b0;
      writes_q <= 1'b0;
      stage_q  <= '0;
      haz_a_q  <= 1'b0;
      stall_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // flush is meaningless here; a simultaneous in_valid still lands.
          if (in_valid) begin
            src_a_q  <= in_src_a;
            src_b_q  <= in_src_b;
            use_a_q  <= in_use_a;
            use_b_q  <= in_use_b;
            dest_q   <= in_dest;
            writes_q <= in_writes;
            stage_q  <= in_stage;
            haz_a_q  <= 1'b0;
            stall_q  <= '0;
            state    <= RD_A;
          end
        end
        RD_A: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            haz_a_q <= haz_now;
            state   <= RD_B;
          end
        end
        RD_B: begin
          if (flush) begin
            state <= IDLE;
          end else if (haz_a_q | haz_now) begin
            // Both sources are re-read every round, so a stale A result is
            // never carried into the next round.
            if (stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
            state <= RD_A;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush || out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SB_FWD_EN
  logic fwd_a_q, fwd_b_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fwd_a_q <= 1'b0;
      fwd_b_q <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        fwd_a_q <= 1'b0;
        fwd_b_q <= 1'b0;
      end
      if (state == RD_A && !flush) fwd_a_q <= fwd_now;
      if (state == RD_B && !flush) fwd_b_q <= fwd_now;
    end
  end

  assign out_fwd_a = fwd_a_q;
  assign out_fwd_b = fwd_b_q;
`else
  assign out_fwd_a = 1'b0;
  assign out_fwd_b = 1'b0;

  // Stage bits and the forwarding threshold only matter with bypassing.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_now, sb_stage, 1'(FWD_STAGE)};
`endif

  // Entry bits between the stage field and the pending flag carry no meaning
  // here; NREG is implied by AW.
  logic unused_cfg;
  assign unused_cfg = ^{sb_data[DW-1:SW], 1'(NREG)};

  always_comb begin
    sb_addr = '0;
    case (state)
      RD_A:    sb_addr = src_a_q;
      RD_B:    sb_addr = src_b_q;
      default: sb_addr = '0;
    endcase
  end

  assign in_ready         = (state == IDLE);
  assign out_valid        = (state == ISSUE);
  assign stall_count      = stall_q;
  assign sb_writeaddr     = dest_q;
  assign sb_registerstage = stage_q;
  // The pending-set fires in the accepting cycle itself, so the hazard read
  // for this instruction always saw the scoreboard before its own write.
  assign sb_enablewrite   = (state == ISSUE) & out_ready & ~flush &
                            writes_q & (dest_q != '0);

endmodule
